// File: rtl/spectrum_capture_if.sv
// Bundle between the capture controller and its host.
// Control, sample stream, status, read port and peak result.
interface spectrum_capture_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              start;
    logic              abort;
    logic [1:0]        avg_log2;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] peak_addr;
    logic [DATA_W-1:0] peak_val;

    modport master (
        output start, abort, avg_log2,
        output in_data, in_valid, in_last, rd_addr,
        input  busy, done, err,
        input  rd_data, peak_addr, peak_val
    );

    modport slave (
        input  start, abort, avg_log2,
        input  in_data, in_valid, in_last, rd_addr,
        output busy, done, err,
        output rd_data, peak_addr, peak_val
    );
endinterface

// File: rtl/spectrum_capture.sv
// Captures and averages 2^avg_log2 FFT magnitude frames, tracks the peak.
// Ports: clk, rst (async high), bus (slave: start/abort, stream, status, read).
module spectrum_capture #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 8,
    parameter int AVG_MAX      = 3,
    parameter int PEAK_MIN_BIN = 1
) (
    input  logic              clk,
    input  logic              rst,
    spectrum_capture_if.slave bus
);
    localparam int N       = 1 << ADDR_W;
    localparam int ACC_W   = DATA_W + AVG_MAX;
    localparam int FRAME_W = (AVG_MAX > 0) ? AVG_MAX : 1;
    localparam logic [1:0] AVG_SAT =
        (AVG_MAX > 3) ? 2'd3 : 2'(AVG_MAX);
    localparam logic [ADDR_W-1:0] PEAK_LO = ADDR_W'(PEAK_MIN_BIN);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SYNC    = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]         state;
    logic [1:0]         avg_q;
    logic [ADDR_W-1:0]  bin;
    logic [FRAME_W-1:0] frame;
    logic [ACC_W-1:0]   acc [N];

    logic [1:0]        avg_in;
    logic [ACC_W-1:0]  ext;
    logic [ACC_W-1:0]  nxt;
    logic [DATA_W-1:0] avg_v;
    logic              final_f;
    logic              bin_end;
    logic              len_err;
    logic              take;

    assign bus.busy = (state == SYNC) || (state == CAPTURE);
    assign bus.done = (state == DONE);

    always_comb begin
        avg_in  = (bus.avg_log2 > AVG_SAT) ? AVG_SAT : bus.avg_log2;
        ext     = ACC_W'(bus.in_data);
        // First frame overwrites, so stale contents never leak in.
        nxt     = (frame == '0) ? ext : acc[bin] + ext;
        avg_v   = DATA_W'(nxt >> avg_q);
        final_f = 32'(frame) == ((32'd1 << avg_q) - 32'd1);
        bin_end = (bin == '1);
        // A frame must end exactly on the last bin.
        len_err = bus.in_last != bin_end;
        take    = (state == CAPTURE) && bus.in_valid && !bus.abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            avg_q         <= '0;
            bin           <= '0;
            frame         <= '0;
            bus.err       <= 1'b0;
            bus.peak_addr <= '0;
            bus.peak_val  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state         <= SYNC;
                        avg_q         <= avg_in;
                        bin           <= '0;
                        frame         <= '0;
                        bus.err       <= 1'b0;
                        bus.peak_addr <= '0;
                        bus.peak_val  <= '0;
                    end
                end
                SYNC: begin
                    if (bus.abort)
                        state <= IDLE;
                    else if (bus.in_valid && bus.in_last)
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (bus.in_valid) begin
                        if (len_err) begin
                            state         <= SYNC;
                            bin           <= '0;
                            frame         <= '0;
                            bus.err       <= 1'b1;
                            bus.peak_addr <= '0;
                            bus.peak_val  <= '0;
                        end else begin
                            // Strict compare keeps the lower bin on ties.
                            if (final_f && bin >= PEAK_LO &&
                                avg_v > bus.peak_val) begin
                                bus.peak_val  <= avg_v;
                                bus.peak_addr <= bin;
                            end
                            if (bin_end) begin
                                bin <= '0;
                                if (final_f)
                                    state <= DONE;
                                else
                                    frame <= frame + 1'b1;
                            end else begin
                                bin <= bin + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (take && !len_err)
            acc[bin] <= nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.rd_data <= '0;
        else if (bus.busy)
            bus.rd_data <= '0;
        else
            bus.rd_data <= DATA_W'(acc[bus.rd_addr] >> avg_q);
    end
endmodule

// File: tb/tb_spectrum_capture.sv
// Directed bench for spectrum_capture with 8-bin frames.
// Table-driven read-back plus hand-written multi-cycle sequences.
module tb_spectrum_capture;
    localparam int DW = 16;
    localparam int AW = 3;

    typedef int frame_t [8];
    typedef struct {
        int addr;
        int exp;
    } rd_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    spectrum_capture_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    spectrum_capture #(
        .DATA_W(DW), .ADDR_W(AW), .AVG_MAX(3), .PEAK_MIN_BIN(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(negedge clk) if (bus.done) done_cnt++;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int d, bit last);
        bus.in_data  = DW'(d);
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic arm(int avg);
        bus.avg_log2 = 2'(avg);
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic feed(frame_t f, bit gap);
        for (int i = 0; i < 8; i++) begin
            if (gap) tick();
            send(f[i], i == 7);
        end
    endtask

    task automatic rd(int a, output int v);
        bus.rd_addr = AW'(a);
        tick();
        v = int'(bus.rd_data);
    endtask

    task automatic abort_pulse();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    initial begin
        frame_t  sig;
        frame_t  junk;
        frame_t  f;
        rd_vec_t tbl [8];
        int      avg_vals [4];
        int      v;
        int      d0;

        sig  = '{50, 3, 9, 40, 7, 40, 2, 1};
        junk = '{500, 600, 700, 800, 900, 1000, 1100, 1200};
        tbl  = '{'{0, 50}, '{1, 3}, '{2, 9}, '{3, 40},
                 '{4, 7}, '{5, 40}, '{6, 2}, '{7, 1}};
        avg_vals = '{10, 20, 30, 41};

        bus.start = 0; bus.abort = 0; bus.avg_log2 = 0;
        bus.in_data = 0; bus.in_valid = 0; bus.in_last = 0;
        bus.rd_addr = 0;

        // Reset state
        repeat (2) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_peak_addr", bus.peak_addr, 0);
        chk("rst_peak_val", bus.peak_val, 0);
        rst = 1'b0;
        tick();

        // Single frame, no averaging
        arm(0);
        chk("sf_busy", bus.busy, 1);
        feed(junk, 0);
        chk("sf_busy_sync", bus.busy, 1);
        d0 = done_cnt;
        feed(sig, 0);
        chk("sf_done", bus.done, 1);
        chk("sf_busy_done", bus.busy, 0);
        tick();
        chk("sf_done_1cyc", bus.done, 0);
        chk("sf_peak_addr", bus.peak_addr, 3);
        chk("sf_peak_val", bus.peak_val, 40);
        for (int i = 0; i < 8; i++) begin
            rd(tbl[i].addr, v);
            chk($sformatf("sf_rd%0d", tbl[i].addr), v, tbl[i].exp);
        end
        chk("sf_done_cnt", done_cnt - d0, 1);

        // Four-frame average on bin 2
        arm(2);
        feed(junk, 0);
        d0 = done_cnt;
        for (int k = 0; k < 4; k++) begin
            f = '{default: 0};
            f[2] = avg_vals[k];
            feed(f, 0);
            if (k == 2) begin
                chk("avg_no_early_done", done_cnt - d0, 0);
                chk("avg_busy", bus.busy, 1);
            end
        end
        chk("avg_done", bus.done, 1);
        tick();
        rd(2, v);
        chk("avg_rd2", v, 25);
        rd(5, v);
        chk("avg_rd5", v, 0);
        chk("avg_peak_addr", bus.peak_addr, 2);
        chk("avg_peak_val", bus.peak_val, 25);
        chk("avg_done_cnt", done_cnt - d0, 1);

        // Early in_last at bin 5
        arm(0);
        feed(junk, 0);
        for (int i = 0; i < 6; i++) send(90, i == 5);
        chk("le_err", bus.err, 1);
        chk("le_busy", bus.busy, 1);
        feed(junk, 0);
        chk("le_err_sync", bus.err, 1);
        chk("le_busy_sync", bus.busy, 1);
        feed(sig, 0);
        chk("le_done", bus.done, 1);
        chk("le_err_hold", bus.err, 1);
        tick();
        chk("le_peak_addr", bus.peak_addr, 3);
        chk("le_peak_val", bus.peak_val, 40);

        // Abort mid second frame
        arm(1);
        chk("ab_err_clr", bus.err, 0);
        feed(junk, 0);
        feed(sig, 0);
        for (int i = 0; i < 3; i++) send(5, 1'b0);
        d0 = done_cnt;
        abort_pulse();
        chk("ab_busy", bus.busy, 0);
        repeat (3) tick();
        chk("ab_no_done", done_cnt - d0, 0);
        chk("ab_err", bus.err, 0);

        // Abort beats start in the same cycle
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("ab_start_busy", bus.busy, 0);

        // Missing in_last at bin 7, then abort from SYNC
        arm(0);
        feed(junk, 0);
        for (int i = 0; i < 8; i++) send(4, 1'b0);
        chk("nl_err", bus.err, 1);
        chk("nl_busy", bus.busy, 1);
        abort_pulse();
        chk("nl_abort_busy", bus.busy, 0);
        chk("nl_err_kept", bus.err, 1);

        // Normal run after abort clears err
        arm(0);
        chk("rr_err_clr", bus.err, 0);
        feed(junk, 0);
        feed(sig, 0);
        chk("rr_done", bus.done, 1);
        tick();
        chk("rr_peak_addr", bus.peak_addr, 3);

        // Gapped valid with a start re-pulse while busy
        arm(0);
        feed(junk, 1);
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                bus.avg_log2 = 2'd2;
                bus.start    = 1'b1;
                tick();
                bus.start    = 1'b0;
            end else begin
                tick();
            end
            send(sig[i], i == 7);
        end
        chk("gp_done", bus.done, 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            rd(tbl[i].addr, v);
            chk($sformatf("gp_rd%0d", tbl[i].addr), v, tbl[i].exp);
        end
        chk("gp_peak_addr", bus.peak_addr, 3);
        chk("gp_peak_val", bus.peak_val, 40);
        chk("gp_done_cnt", done_cnt - d0, 1);

        // Async reset between edges
        arm(0);
        feed(junk, 0);
        for (int i = 0; i < 4; i++) send(sig[i], 1'b0);
        chk("ar_peak_pre", bus.peak_val, 40);
        d0 = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy", bus.busy, 0);
        chk("ar_done", bus.done, 0);
        chk("ar_peak_addr", bus.peak_addr, 0);
        chk("ar_peak_val", bus.peak_val, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("ar_no_done", done_cnt - d0, 0);
        chk("ar_busy_after", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
